pwm_from_count: RTL
===================

PWM_FROM_COUNT -- requirements
Module: pwm_from_count

Downstream consumer of the 4-bit loadable up-counter: converts its count into a PWM waveform, marks period boundaries and flags count discontinuities.

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 count_in  input  4  count value from the upstream counter, sampled every rising edge.
REQ-005 enable  input  1  1 = PWM output active; 0 = pwm_out forced low.
REQ-006 duty_in  input  4  new duty value.
REQ-007 duty_wr  input  1  single-cycle write strobe for duty_in.
REQ-008 clear_flags  input  1  clears jump_flag and period_cnt.
REQ-009 pwm_out  output  1  registered PWM output.
REQ-010 period_done  output  1  single-cycle pulse per detected wrap.
REQ-011 duty_pending  output  1  a written duty value is waiting for the next period boundary.
REQ-012 jump_flag  output  1  sticky flag: count discontinuity seen.
REQ-013 period_cnt  output  8  number of wraps seen, modulo 256.

Function
REQ-014 Internal state SHALL consist of prev_cnt[3:0], prev_valid, pend_duty[3:0], act_duty[3:0] and all registered outputs.
REQ-015 prev_cnt SHALL load count_in every cycle; prev_valid SHALL be set the first cycle after reset and stay set.
REQ-016 Classification SHALL be combinational on count_in vs prev_cnt, qualified by prev_valid:
- step: count_in == prev_cnt+1 mod 16.
- hold: count_in == prev_cnt.
- jump: any other value.
REQ-017 wrap SHALL be the step with prev_cnt==15 and count_in==0; a load to 0 from any other value is a jump, not a wrap.
REQ-018 On wrap, period_done SHALL be 1 in the following cycle only; period_cnt SHALL increment, with 255 -> 0.
REQ-019 On jump, jump_flag SHALL set in the following cycle and hold until clear_flags.
REQ-020 clear_flags SHALL zero jump_flag and period_cnt next cycle; a coincident jump or wrap SHALL win:
- jump_flag = 1.
- period_cnt = 1.
REQ-021 duty_wr SHALL load pend_duty with duty_in and set duty_pending; a later write before a wrap SHALL overwrite pend_duty.
REQ-022 On wrap with duty_pending=1, act_duty SHALL take pend_duty and duty_pending SHALL clear.
REQ-023 If duty_wr coincides with a wrap:
- the previously pending value (if any) is applied.
- the new value becomes pending; duty_pending stays 1.
REQ-024 pwm_out SHALL register enable && (count_in < act_duty), giving 1-cycle latency.
- act_duty=0: pwm_out stays low.
- act_duty=15: pwm_out high for counts 0..14.
REQ-025 With enable=0, pwm_out SHALL be 0 next cycle; classification, period_cnt, jump_flag and duty handling SHALL continue unaffected.
REQ-026 During a hold (upstream paused), outputs SHALL keep following the comparison; no period_done SHALL be produced.

Reset
REQ-027 Asserting reset SHALL immediately drive all outputs and internal registers to 0, including prev_valid, act_duty and pend_duty.
REQ-028 The first cycle after reset release SHALL NOT classify (prev_valid=0), so no jump_flag from the reset-to-count discontinuity.
REQ-029 Reset mid-period SHALL discard any pending duty; act_duty returns to 0.

Verification
REQ-030 Reset, enable=1, duty_wr=1 duty_in=5, count 0..15..0..15 -> duty_pending=1 until first wrap; then pwm_out high 5 cycles per 16, 1 cycle behind count 0..4; period_done single pulse per wrap.
REQ-031 Count 3,4,5 then load 11 (sequence 5,11,12) -> jump_flag=1 the cycle after 11 and stays 1; period_cnt unchanged.
REQ-032 jump and clear_flags in the same cycle -> jump_flag=1; clear_flags alone later -> jump_flag=0 and period_cnt=0.
REQ-033 duty_wr 9 mid-period, then duty_wr 2 on the exact wrap cycle -> act_duty=9 from that wrap, duty_pending=1, and act_duty=2 after the next wrap.
REQ-034 256 wraps -> period_cnt returns to 0; count held at 7 for 10 cycles -> no period_done, no jump_flag.
REQ-035 Reset asserted asynchronously mid-period with duty pending -> all outputs 0 immediately; first post-reset count value raises no jump_flag.

Source files
------------

// File: rtl/pwm_from_count.sv
// PWM generator driven by an upstream 4-bit counter. It also marks wraps with a pulse and counts them,
// flags count discontinuities, and double-buffers duty updates so a new duty takes effect only at a wrap.
module pwm_from_count (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count_in,
  input  logic       enable,
  input  logic [3:0] duty_in,
  input  logic       duty_wr,
  input  logic       clear_flags,
  output logic       pwm_out,
  output logic       period_done,
  output logic       duty_pending,
  output logic       jump_flag,
  output logic [7:0] period_cnt
);

  logic [3:0] prev_cnt_q;
  logic       prev_valid_q;
  logic [3:0] pend_duty_q, pend_duty_d;
  logic [3:0] act_duty_q,  act_duty_d;
  logic       pending_q,   pending_d;
  logic       pwm_q,       pwm_d;
  logic       done_q,      done_d;
  logic       jump_q,      jump_d;
  logic [7:0] pcnt_q,      pcnt_d;

  logic is_step, is_hold, is_jump, is_wrap;

  always_comb begin
    is_step = prev_valid_q && (count_in == prev_cnt_q + 4'd1);
    is_hold = prev_valid_q && (count_in == prev_cnt_q);
    is_jump = prev_valid_q && !is_step && !is_hold;
    is_wrap = is_step && (prev_cnt_q == 4'd15);
  end

  always_comb begin
    pwm_d  = enable && (count_in < act_duty_q);
    done_d = is_wrap;

    // An event in the same cycle as clear_flags overrides the clear.
    jump_d = jump_q;
    if (is_jump)
      jump_d = 1'b1;
    else if (clear_flags)
      jump_d = 1'b0;

    pcnt_d = pcnt_q;
    if (is_wrap)
      pcnt_d = clear_flags ? 8'd1 : pcnt_q + 8'd1;
    else if (clear_flags)
      pcnt_d = '0;

    act_duty_d  = act_duty_q;
    pend_duty_d = pend_duty_q;
    pending_d   = pending_q;
    if (is_wrap && pending_q)
      act_duty_d = pend_duty_q;
    // A write coinciding with a wrap is kept pending for the following wrap.
    if (duty_wr) begin
      pend_duty_d = duty_in;
      pending_d   = 1'b1;
    end else if (is_wrap) begin
      pending_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cnt_q   <= '0;
      prev_valid_q <= 1'b0;
      pend_duty_q  <= '0;
      act_duty_q   <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= 1'b0;
      done_q       <= 1'b0;
      jump_q       <= 1'b0;
      pcnt_q       <= '0;
    end else begin
      prev_cnt_q   <= count_in;
      prev_valid_q <= 1'b1;
      pend_duty_q  <= pend_duty_d;
      act_duty_q   <= act_duty_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      done_q       <= done_d;
      jump_q       <= jump_d;
      pcnt_q       <= pcnt_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_done  = done_q;
  assign duty_pending = pending_q;
  assign jump_flag    = jump_q;
  assign period_cnt   = pcnt_q;

endmodule
